// File: rtl/mac_accumulator.sv
// mac_accumulator: sums the signed products of a 2-cycle Baugh-Wooley multiplier
// into frames and returns one sum per frame on a valid/ready output.
// A local valid/last pipeline (v1/l1, v2/l2) tracks the multiplier latency.
// Optional feature macro MAC_ACC_SAT_EN: when defined, the accumulator clamps
// on overflow instead of wrapping. out_ovf is set in both builds.
//
// state  | meaning
// S_ACC  | accumulator open, products are summed as they arrive
// S_HOLD | frame complete, waiting for the output register to drain
module mac_accumulator #(
  parameter int MUL_SIZE   = 32,
  parameter int GUARD_BITS = 8,
  parameter int CNT_W      = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_valid,
  input  logic                                      in_last,
  output logic                                      in_ready,
  input  logic        [2*MUL_SIZE-1:0]              prod,
  output logic signed [2*MUL_SIZE+GUARD_BITS-1:0]   out_data,
  output logic        [CNT_W-1:0]                   out_cnt,
  output logic                                      out_ovf,
  output logic                                      out_valid,
  input  logic                                      out_ready
);

  localparam int ACC_W = 2*MUL_SIZE+GUARD_BITS;

  typedef enum logic {S_ACC = 1'b0, S_HOLD = 1'b1} state_t;

  state_t state, state_nxt;

  logic v1, l1, v2, l2;
  logic accept;
  logic out_free;
  logic add_en, load_direct, load_hold;

  logic signed [2*MUL_SIZE-1:0] prod_s;
  logic signed [ACC_W-1:0]      prod_ext;
  logic signed [ACC_W-1:0]      acc, sum, acc_upd;
  logic        [CNT_W-1:0]      cnt, cnt_upd;
  logic                         ovf, ovf_upd, add_ovf;

  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  assign prod_s   = prod;
  assign prod_ext = ACC_W'(prod_s);
  assign sum      = acc + prod_ext;
  // Overflow: both addends share a sign and the result's sign differs.
  assign add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  assign ovf_upd  = ovf || add_ovf;
  assign cnt_upd  = cnt + CNT_W'(1);

`ifdef MAC_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  assign acc_upd = add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign acc_upd = sum;
`endif

  // Beat pipeline mirroring the multiplier's input and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      v2 <= 1'b0;
      l2 <= 1'b0;
    end else begin
      v1 <= accept;
      l1 <= accept && in_last;
      v2 <= v1;
      l2 <= l1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_ACC;
    else        state <= state_nxt;
  end

  // Next-state logic: a completed frame parks in HOLD only if the output is busy.
  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:  if (v2 && l2 && !out_free) state_nxt = S_HOLD;
      S_HOLD: if (out_ready)             state_nxt = S_ACC;
      default:                           state_nxt = S_ACC;
    endcase
  end

  // FSM outputs: no beat is accepted while a last is still in the pipeline.
  always_comb begin
    in_ready    = (state == S_ACC) && !(v1 && l1) && !(v2 && l2);
    add_en      = (state == S_ACC) && v2;
    load_direct = (state == S_ACC) && v2 && l2 && out_free;
    load_hold   = (state == S_HOLD) && out_ready;
  end

  // Accumulator: add each valid product; clear once the frame is handed off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (load_direct || load_hold) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (add_en) begin
      acc <= acc_upd;
      cnt <= cnt_upd;
      ovf <= ovf_upd;
    end
  end

  // Output register: a same-edge drain and load keeps out_valid high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (load_direct) begin
      out_data  <= acc_upd;
      out_cnt   <= cnt_upd;
      out_ovf   <= ovf_upd;
      out_valid <= 1'b1;
    end else if (load_hold) begin
      out_data  <= acc;
      out_cnt   <= cnt;
      out_ovf   <= ovf;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Downstream consumer of the signed Baugh-Wooley array multiplier. It accumulates a stream of signed products into frames, such as FIR taps or dot-product terms, and returns one sum per frame on a valid/ready output. The block tracks the multiplier's fixed 2-cycle latency with its own valid/last pipeline, so the upstream source handshakes with this block and drives the multiplier's operand inputs directly.

## Interface
Parameters:
- `MUL_SIZE`, default 32: operand width of the paired multiplier. Product width is 2*MUL_SIZE.
- `GUARD_BITS`, default 8: extra accumulator MSBs. ACC_W = 2*MUL_SIZE+GUARD_BITS.
- `CNT_W`, default 16: width of the per-frame beat counter.

Ports:
- `clk`  in  1  sole clock. Rising edge.
- `reset`  in  1  asynchronous, active-low. Shared with the multiplier.
- `in_valid`  in  1  the source is presenting operands to the multiplier's A_in/B_in this cycle.
- `in_last`  in  1  this beat closes the frame. Qualified by in_valid.
- `in_ready`  out  1  beat accepted on the edge where in_valid && in_ready. Operands must be presented to the multiplier only on accepted beats.
- `prod`  in  2*MUL_SIZE  multiplier C output, signed.
- `out_data`  out  ACC_W  frame sum, signed two's complement.
- `out_cnt`  out  CNT_W  number of beats in the frame. Wraps modulo 2^CNT_W.
- `out_ovf`  out  1  the frame overflowed ACC_W (sticky per frame).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes the result on the edge where out_valid && out_ready.

## Operation
- Beat pipeline: v1/l1 are registered on the acceptance edge, alongside the multiplier's input register. v2/l2 are registered on the next edge, alongside the multiplier's output register. When v2=1, `prod` is valid and is summed on the following edge.
- `prod` is sign-extended to ACC_W before each add.
- FSM states:
  - ACC: the accumulator is open. Reset state, acc=0, cnt=0.
  - HOLD: the frame is complete but the output register is occupied.
- Transitions and actions:
  - ACC, v2 && !l2: acc += prod, cnt += 1, ovf |= overflow.
  - ACC, v2 && l2, output free (!out_valid, or out_valid && out_ready this edge): load out_data/out_cnt/out_ovf with the final sum, count and flag. Set out_valid=1. Clear acc, cnt and ovf. Stay in ACC.
  - ACC, v2 && l2, output occupied and not draining: acc/cnt/ovf take their final values. Go to HOLD.
  - HOLD, out_ready: out_* <= acc/cnt/ovf, out_valid stays 1, clear acc/cnt/ovf, go to ACC.
  - out_valid && out_ready with no new load: out_valid <= 0.
- in_ready = (state==ACC) && !(v1&&l1) && !(v2&&l2). No beat may follow a last until that last has been summed. This bounds in-flight products to 2 and means the non-stallable multiplier pipeline never needs to stall.
- Overflow: the sign of the exact sum differs from the ACC_W result, i.e. both operands share a sign and the result's sign differs.
- Reset mid-frame: the frame and any in-flight beats are discarded. The multiplier clears on the same reset.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_cnt=0, out_ovf=0, state=ACC.
- A beat accepted at edge N is summed at edge N+2.
- A last accepted at edge N with the output free gives out_valid=1 after edge N+2, and in_ready=1 again after edge N+2.
- Minimum frame cadence: a 1-beat frame every 3 cycles. A K-beat frame takes K+2 cycles.
- Single-beat frame: out_data = sign-extended prod, out_cnt=1.
- Same-edge drain and load (ACC) is lossless: the new result replaces the old one, and out_valid stays 1.

## Configuration
- `MAC_ACC_SAT_EN` defined: on overflow the accumulator clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1), and later adds continue from the clamped value. out_ovf still sets.
- `MAC_ACC_SAT_EN` undefined: two's-complement wrap, with out_ovf set.

## Test plan
The bench instantiates the multiplier and this block with MUL_SIZE=32 and GUARD_BITS=8.
- 3-beat frame (3×4, −5×6, 7×−2) with out_ready=1 → out_data=−32, out_cnt=3, out_ovf=0. out_valid asserts 2 edges after the last is accepted.
- Single-beat frame (−2^31 × −2^31) → out_data=2^62, out_cnt=1.
- out_ready held low across two frames (sums 10, then 20) → the first result is held, the FSM enters HOLD, and in_ready=0. After out_ready rises: 10, then 20, each delivered once, with none lost.
- 300 beats of (2^31−1)×(2^31−1) with GUARD_BITS=0 → out_ovf=1. Without the macro the wrapped value matches the model. With `MAC_ACC_SAT_EN`, out_data=2^63−1.
- Reset asserted mid-frame with 2 beats in flight → after release: out_valid=0, and the next 1-beat frame (5×5) returns exactly 25 with out_cnt=1.
- in_valid=1 every cycle with in_last on every 4th beat → in_ready drops for 2 cycles after each last, and no beat is ever summed into the wrong frame.
